// File: rtl/memory_cycle_ctrl.sv
// M stage of the 18-bit pipeline: runs a req/ack handshake to data memory,
// stalls the upstream stages while an access is outstanding, aborts an access
// that waits too long, and registers the MEM/WB pipeline bank.
module memory_cycle_ctrl #(
  parameter int DATA_W  = 18,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic [4:0]        RD_M,
  input  logic [DATA_W-1:0] PCPlus4M,
  input  logic [DATA_W-1:0] ALU_ResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [1:0]        RGB_M,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              StallM,
  output logic              MemErr,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [4:0]        RD_W,
  output logic [DATA_W-1:0] ALU_ResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] PCPlus4W,
  output logic [1:0]        RGB_W,
  output logic [DATA_W-1:0] ResultW
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   wait_cnt, cnt_nx;
  logic               err_nx;
  logic               access;
  logic               timeout_hit;

  // A store and a load flag together still count as one access; mem_we picks store.
  assign access      = MemWriteM | ResultSrcM;
  assign timeout_hit = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT)) && !mem_ack;

  // Memory address/data pass straight through; upper address bits are ignored.
  assign mem_we    = MemWriteM;
  assign mem_addr  = ALU_ResultM[ADDR_W-1:0];
  assign mem_wdata = WriteDataM;

  // State register: FSM state, wait counter and sticky timeout flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      MemErr   <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= cnt_nx;
      MemErr   <= err_nx;
    end
  end

  // Next-state logic: enter WAIT on an un-acked request, leave on ack or timeout.
  // NOTE: every variable gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_nx = state;
    cnt_nx   = wait_cnt;
    err_nx   = MemErr;
    unique case (state)
      S_IDLE: begin
        if (access && !mem_ack) begin
          state_nx = S_WAIT;
          cnt_nx   = CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_nx = S_IDLE;
        end else if (timeout_hit) begin
          state_nx = S_IDLE;
          err_nx   = 1'b1;
        end else begin
          cnt_nx = wait_cnt + CNT_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Output logic: request and stall; reset drops the request in the same cycle.
  always_comb begin
    mem_req = !rst && (((state == S_IDLE) && access) || (state == S_WAIT));
    StallM  = mem_req && !mem_ack && !timeout_hit;
  end

  // MEM/WB bank: capture when not stalled, insert a write-enable bubble while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      PCPlus4W    <= '0;
      RGB_W       <= '0;
    end else if (!StallM) begin
      // A timed-out load must never reach the register file.
      RegWriteW   <= RegWriteM && !(ResultSrcM && timeout_hit);
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= mem_ack ? mem_rdata : '0;
      PCPlus4W    <= PCPlus4M;
      RGB_W       <= RGB_M;
    end else begin
      RegWriteW   <= 1'b0;
    end
  end

  // Write-back result feeding the execute-stage forwarding muxes.
  assign ResultW = ResultSrcW ? ReadDataW : ALU_ResultW;

endmodule

// File: tb/tb_memory_cycle_ctrl.sv
// Directed bench for memory_cycle_ctrl: zero-wait load, multi-wait store,
// back-to-back ALU op, ack exactly at the timeout limit, reset mid-wait,
// and a load that times out.
module tb_memory_cycle_ctrl;

  localparam int DATA_W  = 18;
  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]        RD_M;
  logic [DATA_W-1:0] PCPlus4M, ALU_ResultM, WriteDataM;
  logic [1:0]        RGB_M;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              StallM, MemErr;
  logic              RegWriteW, ResultSrcW;
  logic [4:0]        RD_W;
  logic [DATA_W-1:0] ALU_ResultW, ReadDataW, PCPlus4W, ResultW;
  logic [1:0]        RGB_W;

  int n_cmp = 0;
  int n_bad = 0;
  int cycles;

  memory_cycle_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .ALU_ResultM(ALU_ResultM),
    .WriteDataM(WriteDataM), .RGB_M(RGB_M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .StallM(StallM), .MemErr(MemErr),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .RGB_W(RGB_W), .ResultW(ResultW)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                           input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] wd);
    RegWriteM   = rw;
    MemWriteM   = mw;
    ResultSrcM  = rs;
    RD_M        = rd;
    ALU_ResultM = alu;
    WriteDataM  = wd;
    PCPlus4M    = alu + 18'd4;
    RGB_M       = rd[1:0];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    set_instr(1'b0, 1'b0, 1'b0, 5'd0, 18'h0, 18'h0);
    tick();
    tick();

    // Reset state
    check("rst_mem_req",   mem_req,   0);
    check("rst_stall",     StallM,    0);
    check("rst_memerr",    MemErr,    0);
    check("rst_regwritew", RegWriteW, 0);
    check("rst_resultw",   ResultW,   0);
    rst = 1'b0;
    tick();

    // Zero-wait load: ack in the request cycle, no stall
    set_instr(1'b1, 1'b0, 1'b1, 5'd3, 18'h00005, 18'h0);
    mem_ack   = 1'b1;
    mem_rdata = 18'h2ABCD;
    #1;
    check("ld0_mem_req",  mem_req,  1);
    check("ld0_mem_we",   mem_we,   0);
    check("ld0_mem_addr", mem_addr, 9'h005);
    check("ld0_stall",    StallM,   0);
    tick();
    check("ld0_readdataw", ReadDataW,  18'h2ABCD);
    check("ld0_resultw",   ResultW,    18'h2ABCD);
    check("ld0_regwritew", RegWriteW,  1);
    check("ld0_rd_w",      RD_W,       3);
    check("ld0_pcplus4w",  PCPlus4W,   18'h00009);

    // Store with 3 wait cycles; upper ALU bits must not reach mem_addr
    set_instr(1'b0, 1'b1, 1'b0, 5'd0, 18'h3FDFF, 18'h12345);
    mem_ack   = 1'b0;
    mem_rdata = 18'h0;
    #1;
    check("st_mem_we",    mem_we,    1);
    check("st_mem_addr",  mem_addr,  9'h1FF);
    check("st_mem_wdata", mem_wdata, 18'h12345);
    check("st_stall_c1",  StallM,    1);
    tick();
    check("st_stall_c2",  StallM,    1);
    check("st_bubble_c2", RegWriteW, 0);
    check("st_hold_rd_w", RD_W,      3);
    tick();
    check("st_stall_c3",  StallM,    1);
    check("st_bubble_c3", RegWriteW, 0);
    tick();
    mem_ack = 1'b1;
    #1;
    check("st_ack_stall",   StallM,  0);
    check("st_ack_mem_req", mem_req, 1);
    tick();
    check("st_regwritew", RegWriteW,   0);
    check("st_alu_w",     ALU_ResultW, 18'h3FDFF);

    // Back-to-back ALU op right after the ack
    set_instr(1'b1, 1'b0, 1'b0, 5'd7, 18'h00042, 18'h0);
    mem_ack = 1'b0;
    #1;
    check("add_mem_req", mem_req, 0);
    check("add_stall",   StallM,  0);
    tick();
    check("add_regwritew", RegWriteW, 1);
    check("add_rd_w",      RD_W,      7);
    check("add_resultw",   ResultW,   18'h00042);

    // Load acked exactly when wait_cnt reaches TIMEOUT: ack wins
    set_instr(1'b1, 1'b0, 1'b1, 5'd5, 18'h00010, 18'h0);
    mem_rdata = 18'h15A5A;
    for (int i = 0; i < TIMEOUT; i++) tick();
    mem_ack = 1'b1;
    #1;
    check("edge_stall",   StallM,  0);
    check("edge_mem_req", mem_req, 1);
    tick();
    check("edge_memerr",    MemErr,    0);
    check("edge_readdataw", ReadDataW, 18'h15A5A);
    check("edge_regwritew", RegWriteW, 1);
    check("edge_resultw",   ResultW,   18'h15A5A);
    mem_ack = 1'b0;

    // Reset during the wait of a load
    set_instr(1'b1, 1'b0, 1'b1, 5'd9, 18'h00020, 18'h0);
    tick();
    tick();
    check("rstw_stall_before", StallM, 1);
    rst = 1'b1;
    #1;
    check("rstw_mem_req", mem_req, 0);
    check("rstw_stall",   StallM,  0);
    check("rstw_rd_w",    RD_W,    0);
    set_instr(1'b0, 1'b0, 1'b0, 5'd0, 18'h0, 18'h0);
    tick();
    rst = 1'b0;
    tick();
    check("rstw_post_mem_req",  mem_req,   0);
    check("rstw_post_regwrite", RegWriteW, 0);
    check("rstw_post_resultw",  ResultW,   0);

    // Load that never gets an ack: 15 stall cycles, then abort
    set_instr(1'b1, 1'b0, 1'b1, 5'd12, 18'h00030, 18'h0);
    mem_rdata = 18'h3FFFF;
    #1;
    cycles = 0;
    while (StallM === 1'b1 && cycles < 40) begin
      cycles++;
      tick();
    end
    check("to_stall_cycles", cycles,  TIMEOUT);
    check("to_mem_req_last", mem_req, 1);
    check("to_memerr_pre",   MemErr,  0);
    tick();
    check("to_memerr",    MemErr,    1);
    check("to_regwritew", RegWriteW, 0);
    check("to_readdataw", ReadDataW, 0);
    check("to_resultw",   ResultW,   0);

    // MemErr is sticky across following non-access instructions
    set_instr(1'b1, 1'b0, 1'b0, 5'd1, 18'h00077, 18'h0);
    tick();
    tick();
    check("sticky_memerr", MemErr,  1);
    check("sticky_result", ResultW, 18'h00077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
